// File: rtl/cus47_decoder.sv
// ---------------------------------------------------------------------------
// cus47_decoder
//
// Main/sub CPU support chip for the System 86 board. Sits between the CUS27
// timing generator and the main CPU bus.
//
//   * Derives quadrature 6809E clocks (E/Q) for the main CPU and an
//     anti-phase pair for the sub CPU from CLK_6M, locked to CLK_2H.
//   * Holds the CPUs in reset for RESET_CYCLES CLK_6M edges after rst.
//   * Latches the VBLANK interrupt until the main CPU acknowledges it.
//   * Decodes main-CPU address bits A[15:10] into memory chip selects,
//     latch write strobes, the video buffer enable and a ROM bank bit.
//
// Ports
//   CLK_6M        in   6.144 MHz system clock, rising edge
//   rst           in   asynchronous reset, active low
//   CLK_2H        in   CLK_6M/4 phase reference from CUS27
//   nVBLK         in   vertical blank, active low
//   nWE           in   main CPU write strobe, active low
//   A[5:0]        in   main CPU address bits [15:10]
//   nRES          out  CPU reset, active low
//   ME, MQ        out  main CPU E/Q clocks
//   SUBE, SUBQ    out  sub CPU E/Q clocks (inverse of ME/MQ)
//   nIRQ          out  main CPU IRQ, active low
//   nSCR0, nSCR1  out  tilemap RAM selects          (0000-1FFF, 2000-3FFF)
//   nSND          out  sound/shared RAM select      (4000-43FF)
//   nOBJ          out  sprite RAM select            (4400-5FFF)
//   nSPGM         out  banked ROM select            (6000-7FFF)
//   nMPGM         out  program ROM select           (8000-FFFF, reads)
//   nLTH0..2      out  scroll/colour latch strobes  (9000, 9400, A000)
//   nBUFEN        out  video-side data buffer enable, active low
//   BANK          out  banked ROM page select
// ---------------------------------------------------------------------------
module cus47_decoder #(
    parameter int RESET_CYCLES = 32
) (
    input  logic       CLK_6M,
    input  logic       rst,
    input  logic       CLK_2H,
    input  logic       nVBLK,
    input  logic       nWE,
    input  logic [5:0] A,
    output logic       nRES,
    output logic       ME,
    output logic       MQ,
    output logic       SUBE,
    output logic       SUBQ,
    output logic       nIRQ,
    output logic       nSCR0,
    output logic       nSCR1,
    output logic       nSND,
    output logic       nOBJ,
    output logic       nSPGM,
    output logic       nMPGM,
    output logic       nLTH0,
    output logic       nLTH1,
    output logic       nLTH2,
    output logic       nBUFEN,
    output logic       BANK
);

    // Address-page codes (A[15:10]) of the write-only registers.
    localparam logic [5:0] ADDR_IRQ_ACK = 6'h21;   // 8400-87FF
    localparam logic [5:0] ADDR_BANK_LO = 6'h22;   // 8800-8BFF
    localparam logic [5:0] ADDR_BANK_HI = 6'h23;   // 8C00-8FFF
    // Latch strobe pages, index 0..2 -> nLTH0..nLTH2 (9000, 9400, A000).
    localparam logic [17:0] LTH_ADDRS   = {6'h28, 6'h25, 6'h24};

    localparam int               CNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RESET_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Phase counter and CPU clocks
    // -----------------------------------------------------------------------
    logic       clk2hPrevReg;
    logic       clk2hRise;
    logic [1:0] phReg;
    logic [1:0] phNext;
    logic       meReg;
    logic       mqReg;
    logic       subeReg;
    logic       subqReg;

    // A CLK_2H rising edge pins the counter to phase 1, so the free-running
    // count and the CUS27 reference can never drift apart.
    assign clk2hRise = CLK_2H & ~clk2hPrevReg;

    always_comb begin
        phNext = phReg + 2'd1;
        if (clk2hRise) begin
            phNext = 2'd1;
        end
    end

    // Clock outputs are registered from the next phase value so that they
    // track the phase counter exactly without a decode glitch on the pins.
    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            clk2hPrevReg <= 1'b0;
            phReg        <= 2'd0;
            meReg        <= 1'b0;
            mqReg        <= 1'b0;
            subeReg      <= 1'b1;
            subqReg      <= 1'b1;
        end else begin
            clk2hPrevReg <= CLK_2H;
            phReg        <= phNext;
            meReg        <= phNext[1];
            mqReg        <= phNext[1] ^ phNext[0];
            subeReg      <= ~phNext[1];
            subqReg      <= ~(phNext[1] ^ phNext[0]);
        end
    end

    assign ME   = meReg;
    assign MQ   = mqReg;
    assign SUBE = subeReg;
    assign SUBQ = subqReg;

    // -----------------------------------------------------------------------
    // Power-on CPU reset
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] resCntReg;
    logic             nResReg;

    // The counter freezes once nRES is released; only rst restarts it.
    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            resCntReg <= '0;
            nResReg   <= 1'b0;
        end else if (!nResReg) begin
            if (resCntReg == RES_LAST) begin
                nResReg <= 1'b1;
            end else begin
                resCntReg <= resCntReg + 1'b1;
            end
        end
    end

    assign nRES = nResReg;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic       decEn;
    logic       wrPhase;
    logic [2:0] lthHit;
    logic [2:0] lthActive;
    logic       irqAck;
    logic       bankClr;
    logic       bankSet;

    // Nothing on the bus is decoded while the CPUs are held in reset.
    assign decEn   = nResReg;
    // Register writes are only honoured during the E-high half of the
    // 6809 bus cycle, when the address and data are stable.
    assign wrPhase = decEn & ~nWE & meReg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gLth
            assign lthHit[gi]    = (A == LTH_ADDRS[gi*6 +: 6]);
            assign lthActive[gi] = wrPhase & lthHit[gi];
        end
    endgenerate

    assign nLTH0 = ~lthActive[0];
    assign nLTH1 = ~lthActive[1];
    assign nLTH2 = ~lthActive[2];

    // The video buffer is opened for every access to the lower half of the
    // map (video RAMs) and for the latch writes in the upper half.
    assign nBUFEN = ~(decEn & (~A[5] | (|lthActive)));

    assign irqAck  = wrPhase & (A == ADDR_IRQ_ACK);
    assign bankClr = wrPhase & (A == ADDR_BANK_LO);
    assign bankSet = wrPhase & (A == ADDR_BANK_HI);

    always_comb begin
        nSCR0 = 1'b1;
        nSCR1 = 1'b1;
        nSND  = 1'b1;
        nOBJ  = 1'b1;
        nSPGM = 1'b1;
        nMPGM = 1'b1;
        if (decEn) begin
            case (A[5:3])
                3'b000: nSCR0 = 1'b0;
                3'b001: nSCR1 = 1'b0;
                3'b010: begin
                    // Only the first 1 KB of the 4000 page is shared RAM;
                    // the remainder belongs to the sprite RAM.
                    if (A[2:0] == 3'b000) begin
                        nSND = 1'b0;
                    end else begin
                        nOBJ = 1'b0;
                    end
                end
                3'b011: nSPGM = 1'b0;
                default: begin
                    // Upper half is ROM for reads; writes there hit the
                    // register pages instead and must not drive the ROM.
                    if (nWE) begin
                        nMPGM = 1'b0;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // VBLANK interrupt
    // -----------------------------------------------------------------------
    logic vblkReg;
    logic vblkPrevReg;
    logic vblkFall;
    logic nIrqReg;

    // Two-stage capture: the first stage synchronises nVBLK, the second
    // provides the previous value for edge detection. Edge (not level)
    // triggering means a still-low nVBLK cannot re-raise an acknowledged IRQ.
    assign vblkFall = vblkPrevReg & ~vblkReg;

    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            vblkReg     <= 1'b1;
            vblkPrevReg <= 1'b1;
            nIrqReg     <= 1'b1;
        end else begin
            vblkReg     <= nVBLK;
            vblkPrevReg <= vblkReg;
            // A new VBLANK wins over a simultaneous acknowledge so that no
            // frame interrupt is ever lost.
            if (vblkFall) begin
                nIrqReg <= 1'b0;
            end else if (irqAck) begin
                nIrqReg <= 1'b1;
            end
        end
    end

    assign nIRQ = nIrqReg;

    // -----------------------------------------------------------------------
    // ROM bank select
    // -----------------------------------------------------------------------
    logic bankReg;

    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            bankReg <= 1'b0;
        end else if (bankSet) begin
            bankReg <= 1'b1;
        end else if (bankClr) begin
            bankReg <= 1'b0;
        end
    end

    assign BANK = bankReg;

endmodule

// File: tb/tb_cus47_decoder.sv
// ---------------------------------------------------------------------------
// tb_cus47_decoder
//
// Directed bench for cus47_decoder. CLK_2H is derived from an edge counter
// (tick) so that, once locked, the DUT phase after edge p is (p+2) mod 4:
// the CLK_2H rise is seen on edges with p mod 4 == 3, forcing phase 1.
// All expected values are worked out from that relation and the address map.
// ---------------------------------------------------------------------------
module tb_cus47_decoder;

    localparam int RESET_CYCLES = 32;

    logic       CLK_6M = 1'b0;
    logic       rst;
    logic       CLK_2H = 1'b0;
    logic       nVBLK;
    logic       nWE;
    logic [5:0] A;
    logic       nRES, ME, MQ, SUBE, SUBQ, nIRQ;
    logic       nSCR0, nSCR1, nSND, nOBJ, nSPGM, nMPGM;
    logic       nLTH0, nLTH1, nLTH2, nBUFEN, BANK;

    int tick = 0;
    int checks = 0;
    int errors = 0;

    // {nSCR0,nSCR1,nSND,nOBJ,nSPGM,nMPGM,nLTH0,nLTH1,nLTH2,nBUFEN}
    logic [9:0] selVec;
    assign selVec = {nSCR0, nSCR1, nSND, nOBJ, nSPGM, nMPGM,
                     nLTH0, nLTH1, nLTH2, nBUFEN};

    cus47_decoder #(.RESET_CYCLES(RESET_CYCLES)) dut (
        .CLK_6M (CLK_6M),
        .rst    (rst),
        .CLK_2H (CLK_2H),
        .nVBLK  (nVBLK),
        .nWE    (nWE),
        .A      (A),
        .nRES   (nRES),
        .ME     (ME),
        .MQ     (MQ),
        .SUBE   (SUBE),
        .SUBQ   (SUBQ),
        .nIRQ   (nIRQ),
        .nSCR0  (nSCR0),
        .nSCR1  (nSCR1),
        .nSND   (nSND),
        .nOBJ   (nOBJ),
        .nSPGM  (nSPGM),
        .nMPGM  (nMPGM),
        .nLTH0  (nLTH0),
        .nLTH1  (nLTH1),
        .nLTH2  (nLTH2),
        .nBUFEN (nBUFEN),
        .BANK   (BANK)
    );

    always #5 CLK_6M = ~CLK_6M;

    // CLK_6M/4 reference, updated 1 ns after each rising edge.
    always @(posedge CLK_6M) begin
        #1;
        tick   = tick + 1;
        CLK_2H = tick[1];
    end

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge.
    task automatic step();
        @(posedge CLK_6M);
        #2;
    endtask

    function automatic logic [3:0] clkExp(input int t);
        int ph;
        logic me, mq;
        ph = (t + 2) & 3;
        me = (ph >= 2);
        mq = (ph == 1) || (ph == 2);
        return {me, mq, ~me, ~mq};
    endfunction

    function automatic logic [9:0] readExp(input int a);
        logic [9:0] v;
        v = 10'h3FF;
        if (a < 8)       v[9] = 1'b0;
        else if (a < 16) v[8] = 1'b0;
        else if (a == 16) v[7] = 1'b0;
        else if (a < 24) v[6] = 1'b0;
        else if (a < 32) v[5] = 1'b0;
        else             v[4] = 1'b0;
        if (a < 32) v[0] = 1'b0;
        return v;
    endfunction

    // {nRES,ME,MQ,SUBE,SUBQ,nIRQ,BANK} and all selects inactive.
    task automatic checkResetState(input string tag);
        checkVal({tag, "_ctl"}, 32'({nRES, ME, MQ, SUBE, SUBQ, nIRQ, BANK}),
                 32'(7'b0001110));
        checkVal({tag, "_sel"}, 32'(selVec), 32'(10'h3FF));
        $display("reset state %s ctl=%b sel=%b", tag,
                 {nRES, ME, MQ, SUBE, SUBQ, nIRQ, BANK}, selVec);
    endtask

    // Release rst just after an edge and count the nRES hold-off.
    task automatic releaseReset(input string tag);
        rst = 1'b1;
        for (int k = 1; k <= RESET_CYCLES + 1; k++) begin
            step();
            checkVal({tag, "_nRES"}, 32'(nRES), 32'(k >= RESET_CYCLES));
        end
        $display("reset release %s nRES=%b", tag, nRES);
    endtask

    // Hold a write for four edges (two of them with E high).
    task automatic doWrite(input logic [5:0] addr);
        step();
        nWE = 1'b0;
        A   = addr;
        repeat (4) step();
        nWE = 1'b1;
        A   = 6'h00;
        $display("write A=%02h BANK=%b nIRQ=%b", addr, BANK, nIRQ);
    endtask

    // Write to a latch page and follow its strobe through a full E cycle.
    task automatic writeStrobe(input logic [5:0] addr, input int bitIdx,
                               input string tag);
        logic [9:0] v;
        step();
        nWE = 1'b0;
        A   = addr;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            #1;
            v = 10'h3FF;
            if (clkExp(tick)[3]) begin
                v[bitIdx] = 1'b0;
                v[0]      = 1'b0;
            end
            checkVal(tag, 32'(selVec), 32'(v));
            $display("latch write A=%02h ME=%b sel=%b", addr, ME, selVec);
        end
        nWE = 1'b1;
        A   = 6'h00;
    endtask

    initial begin
        rst   = 1'b0;
        nVBLK = 1'b1;
        nWE   = 1'b1;
        A     = 6'h00;

        // Power-on reset state, with A=00 so an ungated decode would show.
        repeat (3) step();
        checkResetState("por");
        releaseReset("por");

        // Clock phases, locked to CLK_2H.
        for (int i = 0; i < 8; i++) begin
            step();
            checkVal("clk_phase", 32'({ME, MQ, SUBE, SUBQ}), 32'(clkExp(tick)));
            $display("clock tick=%0d ME/MQ/SUBE/SUBQ=%b", tick, {ME, MQ, SUBE, SUBQ});
        end

        // Read sweep of all 64 pages.
        for (int a = 0; a < 64; a++) begin
            step();
            A = 6'(a);
            #1;
            checkVal("read_sel", 32'(selVec), 32'(readExp(a)));
            checkVal("read_onehot", 32'($countones(selVec[9:4])), 32'd5);
            $display("read A=%02h sel=%b", A, selVec);
        end
        A = 6'h00;

        // Latch strobes follow E during the write.
        writeStrobe(6'h24, 3, "lth0");
        writeStrobe(6'h25, 2, "lth1");
        writeStrobe(6'h28, 1, "lth2");

        // Bank select.
        doWrite(6'h23);
        checkVal("bank_set", 32'(BANK), 32'd1);
        doWrite(6'h22);
        checkVal("bank_clr", 32'(BANK), 32'd0);
        doWrite(6'h23);
        checkVal("bank_set2", 32'(BANK), 32'd1);

        // Pending IRQ and BANK=1, then reset mid-operation.
        nVBLK = 1'b0;
        repeat (3) step();
        checkVal("irq_pre_rst", 32'(nIRQ), 32'd0);
        rst = 1'b0;
        #1;
        checkResetState("midrst");
        nVBLK = 1'b1;
        step();
        releaseReset("midrst");

        // VBLANK falling edge -> nIRQ low two edges later, held until ack.
        step();
        nVBLK = 1'b0;
        step();
        checkVal("irq_edge1", 32'(nIRQ), 32'd1);
        step();
        checkVal("irq_edge2", 32'(nIRQ), 32'd0);
        repeat (5) step();
        checkVal("irq_hold", 32'(nIRQ), 32'd0);
        doWrite(6'h21);
        checkVal("irq_ack", 32'(nIRQ), 32'd1);
        repeat (6) step();
        checkVal("irq_level_low", 32'(nIRQ), 32'd1);
        $display("irq sequence nIRQ=%b", nIRQ);

        // Acknowledge on the same edge as a new VBLANK fall: set wins.
        nVBLK = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 4 && (tick & 3) != 3; i++) step();
        nVBLK = 1'b0;
        step();
        nWE = 1'b0;
        A   = 6'h21;
        #1;
        checkVal("irq_pre_both", 32'(nIRQ), 32'd1);
        step();
        nWE = 1'b1;
        A   = 6'h00;
        #1;
        checkVal("irq_set_wins", 32'(nIRQ), 32'd0);
        repeat (3) step();
        checkVal("irq_set_hold", 32'(nIRQ), 32'd0);
        $display("irq set/ack collision nIRQ=%b", nIRQ);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
